// File: rtl/pipe_ctrl.sv
// MIPS 5-stage pipeline sequencing: memory-stall handshake, load-use bubble, branch flush.
// Stage load enables are combinational from state and inputs; bus_err and stall_cnt are registered.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic        dmem_ack,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        pc_ld,
  output logic        ifid_ld,
  output logic        idex_ld,
  output logic        exmem_ld,
  output logic        memwb_ld,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        bus_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic        r_bus_err;
  logic [15:0] r_stall_cnt;
  logic        w_mem_op;
  logic        w_lu_haz;
  logic        w_advance;

  assign w_mem_op = exmem_memread | exmem_memwrite;
  assign w_lu_haz = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_nxt  = r_wait_cnt;
    dmem_req    = 1'b0;
    w_advance   = 1'b0;
    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exmem_ld    = 1'b0;
    memwb_ld    = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_op) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            w_advance = 1'b1;
          end else begin
            w_next     = MEM_WAIT;
            w_wait_nxt = 8'd1;
          end
        end else begin
          w_advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          w_advance  = 1'b1;
          w_wait_nxt = 8'd0;
          w_next     = RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next = ERROR;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      ERROR: begin
        w_next = ERROR;
      end
      default: begin
        w_next     = RUN;
        w_wait_nxt = 8'd0;
      end
    endcase

    // A stalled or trapped pipe leaves every enable, bubble and flush low.
    if (w_advance) begin
      if (w_lu_haz) begin
        idex_ld     = 1'b1;
        exmem_ld    = 1'b1;
        memwb_ld    = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        pc_ld      = 1'b1;
        ifid_ld    = 1'b1;
        idex_ld    = 1'b1;
        exmem_ld   = 1'b1;
        memwb_ld   = 1'b1;
        ifid_flush = branch_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_err   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_next == ERROR) begin
        r_bus_err <= 1'b1;
      end
      if ((r_state != ERROR) && !pc_ld && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus_err   = r_bus_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a request-age reference model.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_memread, exmem_memwrite, dmem_ack, idex_memread, branch_taken;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        dmem_req, pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
  logic        idex_bubble, ifid_flush, bus_err;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: age = cycles an unacknowledged request has been outstanding.
  int m_age;
  bit m_err;
  int m_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .dmem_ack(dmem_ack), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld),
    .exmem_ld(exmem_ld), .memwb_ld(memwb_ld), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit e_req();
    if (m_err) return 1'b0;
    return (m_age > 0) || exmem_memread || exmem_memwrite;
  endfunction

  function automatic bit e_stalled();
    return m_err || (e_req() && !dmem_ack);
  endfunction

  function automatic bit e_lu();
    return idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  task automatic check_model();
    bit adv, lu;
    adv = !e_stalled();
    lu  = e_lu();
    chk("dmem_req",    {15'd0, dmem_req},    {15'd0, e_req()});
    chk("pc_ld",       {15'd0, pc_ld},       {15'd0, adv && !lu});
    chk("ifid_ld",     {15'd0, ifid_ld},     {15'd0, adv && !lu});
    chk("idex_ld",     {15'd0, idex_ld},     {15'd0, adv});
    chk("exmem_ld",    {15'd0, exmem_ld},    {15'd0, adv});
    chk("memwb_ld",    {15'd0, memwb_ld},    {15'd0, adv});
    chk("idex_bubble", {15'd0, idex_bubble}, {15'd0, adv && lu});
    chk("ifid_flush",  {15'd0, ifid_flush},  {15'd0, adv && !lu && branch_taken});
    chk("bus_err",     {15'd0, bus_err},     {15'd0, m_err});
    chk("stall_cnt",   stall_cnt,            16'(m_cnt));
  endtask

  task automatic model_clock();
    bit pc_exp;
    if (rst) return;
    pc_exp = !e_stalled() && !e_lu();
    if (!m_err && !pc_exp && m_cnt < 65535) m_cnt++;
    if (!m_err) begin
      if (e_req() && !dmem_ack) begin
        m_age++;
        if (m_age >= TO) m_err = 1'b1;
      end else begin
        m_age = 0;
      end
    end
  endtask

  task automatic cyc(input bit mr, input bit mw, input bit ack, input bit imr,
                     input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt,
                     input bit br);
    exmem_memread = mr; exmem_memwrite = mw; dmem_ack = ack; idex_memread = imr;
    idex_rt = irt; ifid_rs = rs; ifid_rt = rt; branch_taken = br;
    #2;
    check_model();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_age = 0; m_err = 1'b0; m_cnt = 0;
    check_model();
    chk("rst_bus_err", {15'd0, bus_err}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    exmem_memread = 0; exmem_memwrite = 0; dmem_ack = 0; idex_memread = 0;
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0; branch_taken = 0;
    m_age = 0; m_err = 0; m_cnt = 0;
    #2;
    do_reset();

    // Idle pipe after reset: everything loads, no request.
    exmem_memread = 0; exmem_memwrite = 0; #1;
    chk("idle_pc_ld", {15'd0, pc_ld}, 16'd1);
    chk("idle_req", {15'd0, dmem_req}, 16'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Load with ack 3 cycles after the first request.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_wait1_req", {15'd0, dmem_req}, 16'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("ld_stall3", stall_cnt, 16'd3);

    // Zero-wait store, then back-to-back loads with immediate ack.
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("zero_wait_cnt", stall_cnt, 16'd3);

    // Load-use hazard, then the same with rt=0.
    cyc(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0);
    cyc(0, 0, 0, 0, 0, 5'd5, 5'd1, 0);
    chk("lu_cnt", stall_cnt, 16'd4);
    cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd1, 0);
    chk("lu_rt0_cnt", stall_cnt, 16'd4);

    // Branch held across a 2-cycle memory wait: flush only on the ack cycle.
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    exmem_memread = 1; dmem_ack = 1; branch_taken = 1; #1;
    chk("br_ack_flush", {15'd0, ifid_flush}, 16'd1);
    cyc(1, 0, 1, 0, 0, 0, 0, 1);
    chk("br_cnt", stall_cnt, 16'd6);

    // Timeout: exactly TO request cycles, then sticky error.
    for (int i = 0; i < TO; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("to_bus_err", {15'd0, bus_err}, 16'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("to_cnt", stall_cnt, 16'd10);
    exmem_memread = 0; dmem_ack = 0;
    do_reset();

    // Ack on the TO-th request cycle is accepted.
    for (int i = 0; i < TO - 1; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ack_last_noerr", {15'd0, bus_err}, 16'd0);

    // Randomized traffic; reset a few cycles after any trap.
    begin
      int err_cycles;
      err_cycles = 0;
      for (int i = 0; i < 600; i++) begin
        cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
        if (m_err) err_cycles++;
        if (err_cycles >= 3) begin
          err_cycles = 0;
          do_reset();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS pipeline. It generates the load enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the ID/EX bubble and IF/ID flush. It covers three cases:
- stalling the whole pipe while a multi-cycle data memory access completes over a req/ack handshake;
- inserting a one-cycle bubble on load-use hazards;
- flushing IF/ID on taken branches.

It also traps a hung memory access and counts stall cycles.

## Interface
Parameters:
- MEM_TIMEOUT, 64, max consecutive cycles dmem_req may stay high without dmem_ack; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exmem_memread  in  1  instruction in MEM stage is a load
- exmem_memwrite  in  1  instruction in MEM stage is a store
- dmem_ack  in  1  data memory completes the current access this cycle
- idex_memread  in  1  instruction in EX stage is a load
- idex_rt  in  5  destination of EX-stage load
- ifid_rs, ifid_rt  in  5 each  source registers of ID-stage instruction
- branch_taken  in  1  branch resolved taken this cycle
- dmem_req  out  1  data memory request
- pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  out  1 each  stage register load enables
- idex_bubble  out  1  zero control fields written into ID/EX
- ifid_flush  out  1  clear IF/ID
- bus_err  out  1  sticky memory-timeout error
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Definitions:
  - mem_op = exmem_memread | exmem_memwrite.
  - lu_haz = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- States: RUN, MEM_WAIT, ERROR. A 8-bit wait_cnt runs alongside.
- **RUN**
  - If mem_op: dmem_req=1.
    - With dmem_ack the same cycle: zero-wait, the pipe advances normally and the state stays RUN.
    - Without ack: all five lds=0, wait_cnt<=1, next MEM_WAIT.
  - If no mem_op: dmem_req=0.
- **MEM_WAIT**
  - dmem_req=1 and all lds=0.
  - On dmem_ack: the pipe advances this cycle (lds per advance rules), wait_cnt<=0, next RUN.
  - If no ack and wait_cnt==MEM_TIMEOUT-1: next ERROR.
  - Otherwise wait_cnt++.
- **ERROR**
  - dmem_req=0, all lds=0, bus_err=1.
  - The only exit is rst.
- Advance rules apply on any cycle the pipe advances (RUN without a pending stall, or the ack cycle). Priority is error > memory stall > load-use > flush.
  - lu_haz: pc_ld=0, ifid_ld=0, idex_ld=1, idex_bubble=1, exmem_ld=1, memwb_ld=1.
  - Else all lds=1, idex_bubble=0.
  - ifid_flush = branch_taken & ~lu_haz.
  - A branch_taken arriving during a memory stall is ignored. The branch unit holds branch_taken until the advancing cycle.
- While the pipe is stalled, idex_bubble=0 and ifid_flush=0.
- stall_cnt:
  - Increments each cycle pc_ld=0 in state RUN or MEM_WAIT.
  - Saturates at 0xFFFF.
  - Does not count in ERROR.
- All outputs except bus_err and stall_cnt are combinational from state and inputs.

## Timing
- Reset (async, immediate): state RUN, wait_cnt=0, bus_err=0, stall_cnt=0.
- Reset outputs: dmem_req follows mem_op; with no hazard inputs, all lds=1 and idex_bubble=0, ifid_flush=0.
- Memory stall length: if ack arrives N cycles after the first request cycle (N=0 means the same cycle), the pipe freezes for exactly N cycles and advances on the ack cycle.
- dmem_req falls the cycle after ack unless the next MEM-stage instruction is also a mem_op. Back-to-back memory ops request on consecutive cycles.
- Timeout, ack never arrives: dmem_req is high for exactly MEM_TIMEOUT cycles, then ERROR from the next cycle. An ack on the MEM_TIMEOUT-th cycle is accepted and there is no error.
- Load-use stall is exactly 1 cycle. lu_haz deasserts once the bubble reaches EX.
- rst mid-access: dmem_req drops immediately and the FSM returns to RUN. Memory must abandon the access.

## Test plan
- Reset, no hazards, mem_op=0 → all lds=1, dmem_req=0, bus_err=0, stall_cnt=0.
- Load in MEM with ack 3 cycles after the first request → lds=0 for 3 cycles, advance on the 4th, stall_cnt=3, dmem_req high 4 cycles.
- Zero-wait store (ack the same cycle) → no stall, stall_cnt unchanged. Back-to-back loads with immediate ack → dmem_req held continuously.
- idex_memread=1, idex_rt=5, ifid_rs=5 → one cycle with pc_ld=ifid_ld=0, idex_bubble=1. Repeat with idex_rt=0 → no stall.
- branch_taken during a 2-cycle memory wait, held until ack → ifid_flush=1 only on the ack cycle.
- MEM_TIMEOUT=4, ack never → dmem_req high 4 cycles, then bus_err=1 and all lds=0. Async rst clears bus_err and restores RUN.
